// File: rtl/router_fsm_np.sv
// router_fsm_np: N-port packet router controller FSM.
// Decodes the header address and sequences header, payload and parity
// writes into the selected output FIFO. Stalls on FIFO-full, waits for a
// busy destination with an optional timeout, and drops packets sent to a
// non-existent port.
//
// Ports:
//   clk, resetn    clock (rising edge), async active-low reset
//   pkt_valid      input byte valid (low with the parity byte)
//   data_in        header address field, used only in DECODE_ADDRESS
//   fifo_full      full flag of the selected FIFO
//   fifo_empty     per-port FIFO empty flags
//   soft_reset     per-port soft-reset requests from the FIFOs
//   parity_done    parity byte has been loaded
//   low_pkt_valid  pkt_valid fell during the full stall
//   write_enb_reg  register-block write enable
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   rst_int_reg, drop_state   one-hot state flags
//   busy           back-pressure to the source
//   dest_sel       one-hot latched destination
//   timeout_err    one-cycle pulse on a wait-timeout drop
module router_fsm_np #(
  parameter int N_PORTS      = 4,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32,
  parameter int TO_W         = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pkt_valid,
  input  logic [ADDR_W-1:0]  data_in,
  input  logic               fifo_full,
  input  logic [N_PORTS-1:0] fifo_empty,
  input  logic [N_PORTS-1:0] soft_reset,
  input  logic               parity_done,
  input  logic               low_pkt_valid,
  output logic               write_enb_reg,
  output logic               detect_add,
  output logic               lfd_state,
  output logic               ld_state,
  output logic               laf_state,
  output logic               full_state,
  output logic               rst_int_reg,
  output logic               drop_state,
  output logic               busy,
  output logic [N_PORTS-1:0] dest_sel,
  output logic               timeout_err
);

  typedef enum logic [3:0] {
    S_DA,
    S_LFD,
    S_LD,
    S_FFS,
    S_LAF,
    S_LP,
    S_CPE,
    S_WTE,
    S_DROP
  } state_t;

  localparam logic [ADDR_W:0] NP_W =
    (ADDR_W+1)'(N_PORTS);
  localparam bit TO_EN = (WAIT_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  state_t             r_state;
  state_t             w_next;
  logic [N_PORTS-1:0] r_dest_sel;
  logic [N_PORTS-1:0] w_dest_next;
  logic [TO_W-1:0]    r_to_cnt;
  logic [TO_W-1:0]    w_to_next;
  logic               r_timeout_err;
  logic               w_timeout_hit;

  logic [N_PORTS-1:0] w_addr_oh;
  logic               w_addr_ok;
  logic               w_addr_empty;
  logic               w_sel_empty;
  logic               w_sel_srst;
  logic               w_to_expired;

  // Header address decode; out-of-range addresses give an all-zero mask.
  always_comb begin
    w_addr_oh = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_addr_oh[i] = (data_in == ADDR_W'(i));
    end
  end

  assign w_addr_ok    = ({1'b0, data_in} < NP_W);
  assign w_addr_empty = |(fifo_empty & w_addr_oh);
  assign w_sel_empty  = |(fifo_empty & r_dest_sel);
  assign w_sel_srst   = |(soft_reset & r_dest_sel);
  assign w_to_expired = TO_EN && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_DA;
      r_dest_sel    <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_dest_sel    <= w_dest_next;
      r_to_cnt      <= w_to_next;
      r_timeout_err <= w_timeout_hit;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_dest_next   = r_dest_sel;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      S_DA: begin
        if (pkt_valid) begin
          w_dest_next = w_addr_oh;
          if (!w_addr_ok) begin
            w_next = S_DROP;
          end else if (w_addr_empty) begin
            w_next = S_LFD;
          end else begin
            w_next = S_WTE;
          end
        end
      end
      S_LFD: w_next = S_LD;
      S_LD: begin
        if (fifo_full) begin
          w_next = S_FFS;
        end else if (!pkt_valid) begin
          w_next = S_LP;
        end
      end
      S_FFS: begin
        if (!fifo_full) begin
          w_next = S_LAF;
        end
      end
      S_LAF: begin
        if (parity_done) begin
          w_next = S_DA;
        end else if (low_pkt_valid) begin
          w_next = S_LP;
        end else begin
          w_next = S_LD;
        end
      end
      S_LP: w_next = S_CPE;
      S_CPE: begin
        w_next = fifo_full ? S_FFS : S_DA;
      end
      S_WTE: begin
        // Empty destination wins over an expiring timeout.
        if (w_sel_empty) begin
          w_next = S_LFD;
        end else if (w_to_expired) begin
          w_next        = S_DROP;
          w_timeout_hit = 1'b1;
        end
      end
      S_DROP: begin
        if (!pkt_valid) begin
          w_next = S_DA;
        end
      end
      default: w_next = S_DA;
    endcase
    // Soft reset of the selected port overrides everything,
    // including a timeout drop.
    if (r_state != S_DA && w_sel_srst) begin
      w_next        = S_DA;
      w_timeout_hit = 1'b0;
    end
  end

  // Counter is zero outside WAIT, so it is already clear on entry.
  always_comb begin
    w_to_next = '0;
    if (r_state == S_WTE && w_next == S_WTE) begin
      w_to_next = r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    detect_add    = (r_state == S_DA);
    lfd_state     = (r_state == S_LFD);
    ld_state      = (r_state == S_LD);
    laf_state     = (r_state == S_LAF);
    full_state    = (r_state == S_FFS);
    rst_int_reg   = (r_state == S_CPE);
    drop_state    = (r_state == S_DROP);
    write_enb_reg = (r_state == S_LD) ||
                    (r_state == S_LAF) ||
                    (r_state == S_LP);
    busy          = !((r_state == S_DA) ||
                      (r_state == S_LD));
    dest_sel      = r_dest_sel;
    timeout_err   = r_timeout_err;
  end

endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: directed bench for router_fsm_np with a
// string-state reference model and per-cycle output comparison.
module tb_router_fsm_np;

  localparam int NP = 3;
  localparam int TO = 8;

  logic          clk;
  logic          resetn;
  logic          pkt_valid;
  logic [1:0]    data_in;
  logic          fifo_full;
  logic [NP-1:0] fifo_empty;
  logic [NP-1:0] soft_reset;
  logic          parity_done;
  logic          low_pkt_valid;
  logic          write_enb_reg;
  logic          detect_add;
  logic          lfd_state;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          rst_int_reg;
  logic          drop_state;
  logic          busy;
  logic [NP-1:0] dest_sel;
  logic          timeout_err;

  router_fsm_np #(
    .N_PORTS(NP),
    .ADDR_W(2),
    .WAIT_TIMEOUT(TO),
    .TO_W(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .soft_reset(soft_reset),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg),
    .detect_add(detect_add),
    .lfd_state(lfd_state),
    .ld_state(ld_state),
    .laf_state(laf_state),
    .full_state(full_state),
    .rst_int_reg(rst_int_reg),
    .drop_state(drop_state),
    .busy(busy),
    .dest_sel(dest_sel),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    run = 1;
  string trace = "";
  int    wen_cnt = 0;
  int    terr_cnt = 0;

  string         m_st = "DA";
  logic [NP-1:0] m_dmask = '0;
  int            m_wait = 0;
  bit            m_terr = 0;

  always @(posedge clk or negedge resetn) begin
    string         nx;
    logic [NP-1:0] nd;
    bit            te;
    int            nw;
    int            a;
    if (!resetn) begin
      m_st    <= "DA";
      m_dmask <= '0;
      m_wait  <= 0;
      m_terr  <= 0;
    end else begin
      nx = m_st;
      nd = m_dmask;
      te = 0;
      nw = 0;
      a  = int'(data_in);
      case (m_st)
        "DA": if (pkt_valid) begin
          if (a >= NP) begin
            nx = "DROP";
            nd = '0;
          end else begin
            nd = NP'(1 << a);
            nx = fifo_empty[a] ? "LFD" : "WTE";
          end
        end
        "LFD": nx = "LD";
        "LD": begin
          if (fifo_full) nx = "FFS";
          else if (!pkt_valid) nx = "LP";
        end
        "FFS": if (!fifo_full) nx = "LAF";
        "LAF": begin
          if (parity_done) nx = "DA";
          else if (low_pkt_valid) nx = "LP";
          else nx = "LD";
        end
        "LP": nx = "CPE";
        "CPE": nx = fifo_full ? "FFS" : "DA";
        "WTE": begin
          if ((fifo_empty & m_dmask) != 0) begin
            nx = "LFD";
          end else if (TO > 0 && m_wait + 1 >= TO) begin
            nx = "DROP";
            te = 1;
          end else begin
            nw = m_wait + 1;
          end
        end
        "DROP": if (!pkt_valid) nx = "DA";
        default: nx = "DA";
      endcase
      if (m_st != "DA" && (soft_reset & m_dmask) != 0) begin
        nx = "DA";
        te = 0;
      end
      m_st    <= nx;
      m_dmask <= nd;
      m_wait  <= nw;
      m_terr  <= te;
    end
  end

  function automatic logic [12:0] exp_vec();
    bit wen;
    bit bsy;
    wen = (m_st == "LD") || (m_st == "LAF") || (m_st == "LP");
    bsy = !((m_st == "DA") || (m_st == "LD"));
    return {m_st == "DA", m_st == "LFD", m_st == "LD",
            m_st == "LAF", m_st == "FFS", m_st == "CPE",
            m_st == "DROP", wen, bsy, m_terr, m_dmask};
  endfunction

  function automatic logic [12:0] got_vec();
    return {detect_add, lfd_state, ld_state, laf_state,
            full_state, rst_int_reg, drop_state,
            write_enb_reg, busy, timeout_err, dest_sel};
  endfunction

  function automatic string dut_st();
    if (detect_add)    return "DA";
    if (lfd_state)     return "LFD";
    if (ld_state)      return "LD";
    if (laf_state)     return "LAF";
    if (full_state)    return "FFS";
    if (rst_int_reg)   return "CPE";
    if (drop_state)    return "DROP";
    if (write_enb_reg) return "LP";
    if (busy)          return "WTE";
    return "??";
  endfunction

  always @(negedge clk) begin
    if (run) begin
      cyc++;
      n_vec++;
      if (got_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL cycle%0d outputs: got %b want %b",
                 cyc, got_vec(), exp_vec());
      end
      trace = {trace, dut_st(), ","};
      if (write_enb_reg) wen_cnt++;
      if (timeout_err) terr_cnt++;
    end
  end

  task automatic drv(input bit pv, input int a,
                     input bit full, input int emp,
                     input int srst, input bit pd,
                     input bit lpv);
    pkt_valid     = pv;
    data_in       = 2'(a);
    fifo_full     = full;
    fifo_empty    = NP'(emp);
    soft_reset    = NP'(srst);
    parity_done   = pd;
    low_pkt_valid = lpv;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic start();
    trace    = "";
    wen_cnt  = 0;
    terr_cnt = 0;
  endtask

  task automatic chk_s(input string nm, input string exp);
    n_vec++;
    if (trace != exp) begin
      n_err++;
      $display("FAIL %s: got %s want %s", nm, trace, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got,
                       input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  initial begin
    resetn = 1;
    pkt_valid = 0;
    data_in = 0;
    fifo_full = 0;
    fifo_empty = 0;
    soft_reset = 0;
    parity_done = 0;
    low_pkt_valid = 0;
    #1 resetn = 0;
    idle();
    chk_i("reset_outputs", int'(got_vec()), 13'h1000);
    idle();
    resetn = 1;
    idle();

    // normal route to port 2
    start();
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(0, 2, 0, 3'b100, 0, 0, 0);
    drv(0, 2, 0, 3'b100, 0, 0, 0);
    drv(0, 2, 0, 3'b100, 0, 0, 0);
    idle();
    chk_s("normal_seq", "DA,LFD,LD,LD,LD,LP,CPE,DA,");
    chk_i("normal_dest", int'(dest_sel), 4);
    chk_i("normal_wen", wen_cnt, 4);

    // full stall, resume into LD
    start();
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(0, 0, 0, 3'b001, 0, 0, 0);
    drv(0, 0, 0, 3'b001, 0, 0, 0);
    drv(0, 0, 0, 3'b001, 0, 0, 0);
    idle();
    chk_s("stall_ld",
      "DA,LFD,LD,FFS,FFS,FFS,LAF,LD,LD,LP,CPE,DA,");

    // full stall with low_pkt_valid
    start();
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(0, 0, 1, 3'b001, 0, 0, 1);
    drv(0, 0, 0, 3'b001, 0, 0, 1);
    drv(0, 0, 0, 3'b001, 0, 0, 1);
    drv(0, 0, 0, 3'b001, 0, 0, 0);
    drv(0, 0, 0, 3'b001, 0, 0, 0);
    idle();
    chk_s("stall_lpv",
      "DA,LFD,LD,FFS,FFS,FFS,LAF,LP,CPE,DA,");

    // CPE sees full, LAF sees parity_done
    start();
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 1, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 1, 0);
    idle();
    chk_s("cpe_full", "DA,LFD,LD,LP,CPE,FFS,LAF,DA,");

    // wait then go
    start();
    drv(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    idle();
    chk_s("wait_go",
      "DA,WTE,WTE,WTE,WTE,WTE,LFD,LD,LP,CPE,DA,");
    chk_i("wait_go_terr", terr_cnt, 0);

    // timeout drop after exactly 8 wait cycles
    start();
    drv(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0);
    idle();
    chk_s("timeout", {"DA,WTE,WTE,WTE,WTE,WTE,WTE,WTE,WTE,",
                      "DROP,DROP,DROP,DA,"});
    chk_i("timeout_terr", terr_cnt, 1);

    // empty on the last wait cycle beats the timeout
    start();
    drv(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(1, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    drv(0, 1, 0, 3'b010, 0, 0, 0);
    idle();
    chk_s("empty_wins", {"DA,WTE,WTE,WTE,WTE,WTE,WTE,WTE,WTE,",
                         "LFD,LD,LP,CPE,DA,"});
    chk_i("empty_wins_terr", terr_cnt, 0);

    // invalid address; soft_reset ignored with no destination
    start();
    drv(1, 3, 0, 3'b111, 0, 0, 0);
    drv(1, 3, 0, 3'b111, 3'b111, 0, 0);
    drv(1, 3, 0, 3'b111, 0, 0, 0);
    drv(0, 3, 0, 3'b111, 0, 0, 0);
    drv(0, 3, 0, 3'b111, 0, 0, 0);
    chk_s("bad_addr", "DA,DROP,DROP,DROP,DA,");
    chk_i("bad_addr_wen", wen_cnt, 0);
    chk_i("bad_addr_dest", int'(dest_sel), 0);

    // soft reset in FFS: other port ignored, own port wins
    start();
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 0, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 0, 0, 0);
    drv(1, 0, 1, 3'b001, 3'b010, 0, 0);
    drv(1, 0, 1, 3'b001, 3'b001, 0, 0);
    idle();
    chk_s("srst_ffs", "DA,LFD,LD,FFS,FFS,DA,");

    // soft reset on the timeout cycle suppresses timeout_err
    start();
    drv(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 3'b010, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0);
    idle();
    chk_s("srst_wte", {"DA,WTE,WTE,WTE,WTE,WTE,WTE,WTE,WTE,",
                       "DA,DA,"});
    chk_i("srst_wte_terr", terr_cnt, 0);

    // async reset mid-LD
    start();
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    resetn = 0;
    #1;
    chk_i("async_rst", int'(got_vec()), 13'h1000);
    drv(1, 2, 0, 3'b100, 0, 0, 0);
    resetn = 1;
    idle();
    chk_s("rst_ld", "DA,LFD,LD,DA,DA,");

    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
